// File: rtl/unreg_pkg.sv
// Shared definitions for the shift-register controller.
//   unreg_op_e    : command opcodes carried on cmd_op
//   unreg_state_e : controller FSM states
//   UNREG_MAX_SHIFT : default register width / largest honoured shift count
package unreg_pkg;

  localparam int unsigned UNREG_MAX_SHIFT = 16;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_CLEAR = 2'b01,
    OP_LOAD  = 2'b10,
    OP_SHIFT = 2'b11
  } unreg_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } unreg_state_e;

endpackage

// File: rtl/unreg_shift_cnt.sv
// Down-counter tracking shift cycles still to issue.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (takes priority over dec)
//   dec       : decrement by one, holding at zero
//   count     : current count
//   zero      : count == 0
module unreg_shift_cnt #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/unreg_ctrl.sv
// Command sequencer for a clear/load/shift register datapath.
// Commands are offered with a valid/ready handshake; each accepted command
// runs IDLE -> EXEC -> DONE (NOP and zero-count SHIFT skip EXEC) and drives
// the register strobes during EXEC.
//   clk, rst        : clock, synchronous active-high reset
//   cmd_valid/ready : command handshake (ready is 0 whenever rst=1)
//   cmd_op, cmd_cnt : opcode and shift count, sampled on accept
//   reg_en/clr/sel  : register update enable, clear, shift(1)/load(0) select
//   busy, done      : executing flag, one-cycle completion pulse
//   remaining       : shift cycles still to issue
// Optional: define UNREG_CTRL_SKID_EN to add a one-entry command buffer so a
// command can be accepted while another is executing.
module unreg_ctrl
  import unreg_pkg::*;
#(
  parameter int unsigned MAX_SHIFT = UNREG_MAX_SHIFT,
  parameter int unsigned CNT_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             reg_en,
  output logic             reg_clr,
  output logic             reg_sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  unreg_state_e     state_q, state_d;
  unreg_op_e        op_q;
  unreg_op_e        cmd_op_e;
  logic [CNT_W-1:0] cmd_n;
  logic             accept;

  logic             start;
  unreg_op_e        start_op;
  logic [CNT_W-1:0] start_n;

  logic             cnt_zero;
  logic             cnt_last;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;

  assign cmd_op_e = unreg_op_e'(cmd_op);
  assign accept   = cmd_valid && cmd_ready;

  // Saturate the requested shift count at MAX_SHIFT.
  always_comb begin
    cmd_n = cmd_cnt;
    if (32'(cmd_cnt) > MAX_SHIFT) begin
      cmd_n = CNT_W'(MAX_SHIFT);
    end
  end

`ifdef UNREG_CTRL_SKID_EN
  logic             skid_full_q;
  unreg_op_e        skid_op_q;
  logic [CNT_W-1:0] skid_n_q;

  assign cmd_ready = !rst && ((state_q == ST_IDLE) || !skid_full_q);

  // A command accepted in DONE with the buffer empty starts directly, so the
  // buffer only ever holds a command taken during EXEC. Leaving DONE with the
  // buffer full launches the buffered command in place of returning to IDLE.
  always_comb begin
    start    = 1'b0;
    start_op = cmd_op_e;
    start_n  = cmd_n;
    if ((state_q == ST_DONE) && skid_full_q) begin
      start    = 1'b1;
      start_op = skid_op_q;
      start_n  = skid_n_q;
    end else if (accept && (state_q != ST_EXEC)) begin
      start = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_full_q <= 1'b0;
    end else if (accept && (state_q == ST_EXEC)) begin
      skid_full_q <= 1'b1;
    end else if ((state_q == ST_DONE) && skid_full_q) begin
      skid_full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_op_q <= OP_NOP;
      skid_n_q  <= '0;
    end else if (accept && (state_q == ST_EXEC)) begin
      skid_op_q <= cmd_op_e;
      skid_n_q  <= cmd_n;
    end
  end
`else
  assign cmd_ready = !rst && (state_q == ST_IDLE);

  always_comb begin
    start    = accept;
    start_op = cmd_op_e;
    start_n  = cmd_n;
  end
`endif

  assign cnt_last     = (remaining == CNT_W'(1));
  assign cnt_load     = start;
  assign cnt_load_val = (start_op == OP_SHIFT) ? start_n : '0;
  assign cnt_dec      = (state_q == ST_EXEC) && (op_q == OP_SHIFT);

  unreg_shift_cnt #(
    .CNT_W (CNT_W)
  ) u_shift_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .count    (remaining),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
    end else begin
      state_q <= state_d;
      if (start) begin
        op_q <= start_op;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    reg_en  = 1'b0;
    reg_clr = 1'b0;
    reg_sel = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_EXEC: begin
        reg_en  = 1'b1;
        reg_clr = (op_q == OP_CLEAR);
        reg_sel = (op_q == OP_SHIFT);
        // The counter shows the cycle being issued, so count==1 is the last.
        if ((op_q != OP_SHIFT) || cnt_last || cnt_zero) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // start only occurs from IDLE or DONE, so it overrides those transitions.
    if (start) begin
      if ((start_op == OP_CLEAR) || (start_op == OP_LOAD) ||
          ((start_op == OP_SHIFT) && (start_n != '0))) begin
        state_d = ST_EXEC;
      end else begin
        state_d = ST_DONE;
      end
    end
  end

endmodule

// File: tb/tb_unreg_ctrl.sv
// Self-checking bench for unreg_ctrl. Expected per-cycle outputs come from a
// command-level model: a command with N execute cycles yields N strobe
// cycles, one done cycle, then idle.
module tb_unreg_ctrl;

  localparam int unsigned MAXS = 16;
  localparam int unsigned CW   = 5;
`ifdef UNREG_CTRL_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [CW-1:0] cmd_cnt = '0;
  logic          reg_en, reg_clr, reg_sel, busy, done;
  logic [CW-1:0] remaining;
  logic [CW+5:0] obs;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned cyc     = 0;

  unreg_ctrl #(
    .MAX_SHIFT (MAXS),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .reg_en    (reg_en),
    .reg_clr   (reg_clr),
    .reg_sel   (reg_sel),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {cmd_ready, busy, done, reg_en, reg_clr, reg_sel, remaining};

  function automatic logic [CW+5:0] pack(input bit rdy, input bit bsy, input bit dn,
                                         input bit en, input bit clr, input bit sel,
                                         input int unsigned rem);
    return {rdy, bsy, dn, en, clr, sel, CW'(rem)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from idle and check every cycle until idle again.
  task automatic run_cmd(input logic [1:0] op, input logic [CW-1:0] cnt, input string name);
    logic [CW+5:0] exp_q[$];
    int unsigned n;
    int unsigned ex;
    int unsigned budget;
    budget = 0;
    while (cmd_ready !== 1'b1 && budget < 50) begin
      step();
      budget++;
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout: cmd_ready=%b want 1", name, cmd_ready);
      return;
    end
    n  = (op == 2'b11) ? ((int'(cnt) > MAXS) ? MAXS : int'(cnt)) : 0;
    ex = (op == 2'b01 || op == 2'b10) ? 1 : n;
    for (int unsigned i = 0; i < ex; i++) begin
      exp_q.push_back(pack(SKID, 1'b1, 1'b0, 1'b1, op == 2'b01, op == 2'b11,
                           (op == 2'b11) ? n - i : 0));
    end
    exp_q.push_back(pack(SKID, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_cnt   = CW'($urandom);
    foreach (exp_q[i]) begin
      if (i != 0) step();
      vectors++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d (t=%0d): got {rdy,busy,done,en,clr,sel,rem}=%b want %b",
                 name, i + 1, cyc, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_cnt   = CW'(5);
    step();
    step();
    vectors++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", obs, {(CW+6){1'b0}});
    end
    cmd_valid = 1'b0;
    rst       = 1'b0;
    #1;
    vectors++;
    if (obs !== pack(1, 0, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", obs, pack(1, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_load_latency();
    while (cyc < 10) step();
    run_cmd(2'b10, CW'($urandom), "load_c10");
  endtask

  task automatic test_shift();
    run_cmd(2'b11, CW'(5), "shift5");
    run_cmd(2'b11, CW'(1), "shift1");
    run_cmd(2'b11, CW'(16), "shift16");
    run_cmd(2'b11, CW'(17), "shift17_sat");
    run_cmd(2'b11, CW'(31), "shift31_sat");
    run_cmd(2'b11, CW'(0), "shift0");
  endtask

  task automatic test_clear_nop();
    run_cmd(2'b01, CW'(9), "clear");
    run_cmd(2'b00, CW'(9), "nop");
  endtask

  task automatic test_abort();
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_cnt   = CW'(8);
    step();
    cmd_valid = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (i != 0) step();
      vectors++;
      if (obs !== pack(SKID, 1, 0, 1, 0, 1, 8 - i)) begin
        errors++;
        $display("FAIL abort_pre cycle %0d: got %b want %b", i + 1, obs, pack(SKID, 1, 0, 1, 0, 1, 8 - i));
      end
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (obs !== pack(0, 1, 0, 1, 0, 1, 6)) begin
      errors++;
      $display("FAIL abort_rst_ready: got %b want %b", obs, pack(0, 1, 0, 1, 0, 1, 6));
    end
    step();
    vectors++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL abort_cleared: got %b want %b", obs, {(CW+6){1'b0}});
    end
    rst = 1'b0;
    #1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i != 0) step();
      vectors++;
      if (obs !== pack(1, 0, 0, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL abort_idle cycle %0d: got %b want %b", i, obs, pack(1, 0, 0, 0, 0, 0, 0));
      end
    end
    run_cmd(2'b10, CW'(3), "after_abort_load");
  endtask

  task automatic test_back_to_back();
    run_cmd(2'b10, CW'(0), "b2b_load");
    run_cmd(2'b01, CW'(0), "b2b_clear");
    run_cmd(2'b11, CW'(2), "b2b_shift2");
    run_cmd(2'b00, CW'(0), "b2b_nop");
  endtask

  task automatic test_random();
    int unsigned gap;
    for (int unsigned k = 0; k < 40; k++) begin
      gap = $urandom_range(0, 2);
      for (int unsigned g = 0; g < gap; g++) begin
        cmd_op  = 2'($urandom);
        cmd_cnt = CW'($urandom);
        step();
        vectors++;
        if (obs !== pack(1, 0, 0, 0, 0, 0, 0)) begin
          errors++;
          $display("FAIL rand_gap %0d: got %b want %b", k, obs, pack(1, 0, 0, 0, 0, 0, 0));
        end
      end
      run_cmd(2'($urandom), CW'($urandom_range(0, 31)), "rand_cmd");
    end
  endtask

`ifdef UNREG_CTRL_SKID_EN
  task automatic test_skid();
    logic [CW+5:0] exp_s[7];
    exp_s[0] = pack(1, 1, 0, 1, 0, 1, 3);  // LOAD offered and accepted here
    exp_s[1] = pack(0, 1, 0, 1, 0, 1, 2);  // buffer full
    exp_s[2] = pack(0, 1, 0, 1, 0, 1, 1);
    exp_s[3] = pack(0, 1, 1, 0, 0, 0, 0);  // SHIFT done
    exp_s[4] = pack(1, 1, 0, 1, 0, 0, 0);  // LOAD strobe
    exp_s[5] = pack(1, 1, 1, 0, 0, 0, 0);
    exp_s[6] = pack(1, 0, 0, 0, 0, 0, 0);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_cnt   = CW'(3);
    step();
    cmd_op  = 2'b10;
    cmd_cnt = CW'(7);
    for (int unsigned i = 0; i < 7; i++) begin
      if (i != 0) step();
      vectors++;
      if (obs !== exp_s[i]) begin
        errors++;
        $display("FAIL skid cycle %0d: got %b want %b", i + 1, obs, exp_s[i]);
      end
      if (i == 0) cmd_valid = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_latency();
    test_shift();
    test_clear_nop();
    test_abort();
    test_back_to_back();
    test_random();
`ifdef UNREG_CTRL_SKID_EN
    test_skid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
